// File: rtl/cam_ctrl_pkg.sv
// Shared types for the CAM request controller.
// CAM_CTRL_FLUSH_EN adds the FLUSH state to the state enum.
package cam_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_MISS = 2'd1,
        ST_DUP  = 2'd2,
        ST_FULL = 2'd3
    } status_e;

`ifdef CAM_CTRL_FLUSH_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_WRITE  = 3'd2,
        S_RESP   = 3'd3,
        S_FLUSH  = 3'd4
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_WRITE  = 2'd2,
        S_RESP   = 2'd3
    } state_e;
`endif

endpackage

// File: rtl/cam_ctrl_free_enc.sv
// Lowest-set-bit priority encoder over the free-entry bitmap.
module free_enc #(
    parameter int DEPTH = 64,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] free_map,
    output logic [ADDR-1:0]  idx,
    output logic             any_free
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx      = '0;
        any_free = |free_map;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (free_map[i-1]) idx = ADDR'(i - 1);
        end
    end

endmodule

// File: rtl/cam_ctrl.sv
// Request-side controller for one write port and one read port of the CAM.
// Optional CAM_CTRL_FLUSH_EN adds a flush input that invalidates every entry.
module cam_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int KEY   = 16,
    parameter int DEPTH = 64,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
`ifdef CAM_CTRL_FLUSH_EN
    input  logic            flush,
`endif
    input  logic            req_valid,
    output logic            req_ready,
    input  op_e             req_op,
    input  logic [KEY-1:0]  req_key,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output status_e         rsp_status,
    output logic [ADDR-1:0] rsp_addr,
    output logic [ADDR:0]   occupancy,
    output logic            full,
    output logic            empty,
    output logic            cam_we,
    output logic [KEY:0]    cam_wm,
    output logic [KEY:0]    cam_wd,
    output logic [ADDR-1:0] cam_waddr,
    output logic            cam_re,
    output logic [KEY:0]    cam_rm,
    output logic [KEY:0]    cam_rd,
    input  logic            cam_match,
    input  logic [ADDR-1:0] cam_raddr
);

    localparam logic [ADDR:0] OCC_MAX = (ADDR + 1)'(DEPTH);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [KEY-1:0]   key_q, key_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    status_e          status_q, status_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DEPTH-1:0] free_q, free_d;
    logic [ADDR:0]    occ_q, occ_d;
    logic             req_ready_c;
    logic [ADDR-1:0]  free_idx;
    logic             any_free;
`ifdef CAM_CTRL_FLUSH_EN
    localparam logic [ADDR-1:0] FLUSH_LAST = ADDR'(DEPTH - 1);
    logic [ADDR-1:0]  flush_cnt_q, flush_cnt_d;
`endif

    free_enc #(
        .DEPTH(DEPTH),
        .ADDR (ADDR)
    ) u_free_enc (
        .free_map(free_q),
        .idx     (free_idx),
        .any_free(any_free)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        key_d       = key_q;
        addr_d      = addr_q;
        status_d    = status_q;
        rsp_valid_d = rsp_valid_q;
        free_d      = free_q;
        occ_d       = occ_q;
        req_ready_c = 1'b0;
        cam_re      = 1'b0;
        cam_rm      = '0;
        cam_rd      = '0;
        cam_we      = 1'b0;
        cam_wm      = '0;
        cam_wd      = '0;
        cam_waddr   = '0;
`ifdef CAM_CTRL_FLUSH_EN
        flush_cnt_d = flush_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
`ifdef CAM_CTRL_FLUSH_EN
                if (flush) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end else begin
                    req_ready_c = 1'b1;
                    if (req_valid) begin
                        op_d    = req_op;
                        key_d   = req_key;
                        state_d = S_SEARCH;
                    end
                end
`else
                req_ready_c = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    key_d   = req_key;
                    state_d = S_SEARCH;
                end
`endif
            end

            S_SEARCH: begin
                cam_re      = (op_q != OP_RSVD);
                cam_rd      = (op_q != OP_RSVD) ? {1'b1, key_q} : '0;
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                status_d    = ST_MISS;
                addr_d      = '0;
                // addr_q carries the write target into WRITE for successful ops.
                case (op_q)
                    OP_LOOKUP: begin
                        if (cam_match) begin
                            status_d = ST_OK;
                            addr_d   = cam_raddr;
                        end
                    end
                    OP_INSERT: begin
                        if (cam_match) begin
                            status_d = ST_DUP;
                            addr_d   = cam_raddr;
                        end else if (!any_free) begin
                            status_d = ST_FULL;
                        end else begin
                            state_d     = S_WRITE;
                            rsp_valid_d = 1'b0;
                            addr_d      = free_idx;
                        end
                    end
                    OP_DELETE: begin
                        if (cam_match) begin
                            state_d     = S_WRITE;
                            rsp_valid_d = 1'b0;
                            addr_d      = cam_raddr;
                        end
                    end
                    default: ;
                endcase
            end

            S_WRITE: begin
                cam_we      = 1'b1;
                cam_waddr   = addr_q;
                cam_wd      = {op_q == OP_INSERT, key_q};
                status_d    = ST_OK;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
                if (op_q == OP_INSERT) begin
                    free_d[addr_q] = 1'b0;
                    occ_d          = occ_q + 1'b1;
                end else begin
                    free_d[addr_q] = 1'b1;
                    occ_d          = occ_q - 1'b1;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

`ifdef CAM_CTRL_FLUSH_EN
            S_FLUSH: begin
                cam_we      = 1'b1;
                cam_waddr   = flush_cnt_q;
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == FLUSH_LAST) begin
                    free_d  = '1;
                    occ_d   = '0;
                    state_d = S_IDLE;
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LOOKUP;
            key_q       <= '0;
            addr_q      <= '0;
            status_q    <= ST_OK;
            rsp_valid_q <= 1'b0;
            free_q      <= '1;
            occ_q       <= '0;
`ifdef CAM_CTRL_FLUSH_EN
            flush_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            key_q       <= key_d;
            addr_q      <= addr_d;
            status_q    <= status_d;
            rsp_valid_q <= rsp_valid_d;
            free_q      <= free_d;
            occ_q       <= occ_d;
`ifdef CAM_CTRL_FLUSH_EN
            flush_cnt_q <= flush_cnt_d;
`endif
        end
    end

    // Hold req_ready low while reset is asserted, not just once state settles.
    assign req_ready  = req_ready_c & reset_n;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_valid_q ? status_q : ST_OK;
    assign rsp_addr   = rsp_valid_q ? addr_q : '0;
    assign occupancy  = occ_q;
    assign full       = (occ_q == OCC_MAX);
    assign empty      = (occ_q == '0);

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl: behavioural CAM plus a key-table reference model.
// Exercises flush as well when built with CAM_CTRL_FLUSH_EN.
module tb_cam_ctrl;
    import cam_ctrl_pkg::*;

    localparam int KEY   = 16;
    localparam int DEPTH = 8;
    localparam int ADDR  = 3;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            rsp_ready = 1'b1;
    op_e             req_op = OP_LOOKUP;
    logic [KEY-1:0]  req_key = '0;
    logic            req_ready, rsp_valid;
    status_e         rsp_status;
    logic [ADDR-1:0] rsp_addr;
    logic [ADDR:0]   occupancy;
    logic            full, empty;
    logic            cam_we, cam_re;
    logic [KEY:0]    cam_wm, cam_wd, cam_rm, cam_rd;
    logic [ADDR-1:0] cam_waddr, cam_raddr;
    logic            cam_match;
`ifdef CAM_CTRL_FLUSH_EN
    logic            flush = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cam_ctrl #(
        .KEY  (KEY),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef CAM_CTRL_FLUSH_EN
        .flush     (flush),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_key   (req_key),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_status(rsp_status),
        .rsp_addr  (rsp_addr),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty),
        .cam_we    (cam_we),
        .cam_wm    (cam_wm),
        .cam_wd    (cam_wd),
        .cam_waddr (cam_waddr),
        .cam_re    (cam_re),
        .cam_rm    (cam_rm),
        .cam_rd    (cam_rd),
        .cam_match (cam_match),
        .cam_raddr (cam_raddr)
    );

    // Behavioural CAM: masked write on the clock edge, combinational lowest-index search.
    logic [KEY:0] cam_mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) cam_mem[i] = '0;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) cam_mem[i] <= '0;
        end else if (cam_we) begin
            cam_mem[cam_waddr] <= (cam_mem[cam_waddr] & cam_wm) | (cam_wd & ~cam_wm);
        end
    end

    always_comb begin
        cam_match = 1'b0;
        cam_raddr = '0;
        if (cam_re) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (((cam_mem[i] ^ cam_rd) & ~cam_rm) == '0) begin
                    cam_match = 1'b1;
                    cam_raddr = ADDR'(i);
                end
            end
        end
    end

    // Reference model: table of stored keys, one slot per CAM entry.
    bit             ref_valid [DEPTH];
    logic [KEY-1:0] ref_key   [DEPTH];
    int             ref_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
        ref_count = 0;
    endtask

    function automatic int model_find(input logic [KEY-1:0] k);
        for (int i = 0; i < DEPTH; i++) if (ref_valid[i] && ref_key[i] == k) return i;
        return -1;
    endfunction

    task automatic model_op(input op_e op, input logic [KEY-1:0] k,
                            output status_e st, output int addr, output bit writes);
        int idx;
        idx    = model_find(k);
        st     = ST_MISS;
        addr   = 0;
        writes = 1'b0;
        case (op)
            OP_LOOKUP: if (idx >= 0) begin st = ST_OK; addr = idx; end
            OP_INSERT: begin
                if (idx >= 0) begin
                    st = ST_DUP; addr = idx;
                end else if (ref_count == DEPTH) begin
                    st = ST_FULL;
                end else begin
                    for (int i = DEPTH - 1; i >= 0; i--) if (!ref_valid[i]) addr = i;
                    ref_valid[addr] = 1'b1;
                    ref_key[addr]   = k;
                    ref_count++;
                    st = ST_OK; writes = 1'b1;
                end
            end
            OP_DELETE: if (idx >= 0) begin
                ref_valid[idx] = 1'b0;
                ref_count--;
                st = ST_OK; addr = idx; writes = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic do_req(input op_e op, input logic [KEY-1:0] k, input int hold,
                          output status_e got_st, output logic [ADDR-1:0] got_addr);
        status_e est;
        int      eaddr, cyc, wes;
        bit      ew, seen;
        model_op(op, k, est, eaddr, ew);
        @(negedge clk);
        check_eq("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_key   = k;
        rsp_ready = (hold == 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0; wes = 0; seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_eq("search_re", cam_re, op != OP_RSVD);
                if (op != OP_RSVD) check_eq("search_rd", cam_rd, {1'b1, k});
            end
            if (cam_we) wes++;
            if (rsp_valid) seen = 1'b1;
        end
        check_eq("rsp_seen", seen, 1);
        got_st   = rsp_status;
        got_addr = rsp_addr;
        if (seen) begin
            check_eq("latency", cyc, ew ? 3 : 2);
            check_eq("status", rsp_status, est);
            check_eq("addr", rsp_addr, eaddr);
            check_eq("we_pulses", wes, ew ? 1 : 0);
            check_eq("occupancy", occupancy, ref_count);
            check_eq("full", full, ref_count == DEPTH);
            check_eq("empty", empty, ref_count == 0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check_eq("hold_valid", rsp_valid, 1);
                check_eq("hold_status", rsp_status, est);
                check_eq("hold_addr", rsp_addr, eaddr);
                check_eq("hold_req_ready", req_ready, 0);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            check_eq("rsp_done", rsp_valid, 0);
        end
        rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_occupancy", occupancy, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_cam_en", {cam_we, cam_re}, 0);
        reset_n = 1'b1;
        model_clear();
    endtask

    initial begin
        status_e         st;
        logic [ADDR-1:0] ad;
        model_clear();
        do_reset();

        do_req(OP_LOOKUP, 16'h0000, 0, st, ad);
        check_eq("lookup0_after_reset", st, ST_MISS);
        do_req(OP_DELETE, 16'h5555, 0, st, ad);
        check_eq("delete_empty_occ", occupancy, 0);
        do_req(OP_INSERT, 16'h1234, 0, st, ad);
        check_eq("ins1234_addr", ad, 0);
        do_req(OP_INSERT, 16'h1234, 0, st, ad);
        check_eq("ins1234_dup", st, ST_DUP);
        do_req(OP_RSVD, 16'h1234, 0, st, ad);
        do_req(OP_LOOKUP, 16'h1234, 5, st, ad);

        // Reset while the insert of a fresh key sits in WRITE.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_INSERT; req_key = 16'h7777;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_write_we", cam_we, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_rsp_valid", rsp_valid, 0);
        check_eq("mid_rst_occupancy", occupancy, 0);
        check_eq("mid_rst_empty", empty, 1);
        reset_n = 1'b1;
        model_clear();
        @(negedge clk);
        check_eq("mid_rst_idle", req_ready, 1);

        for (int i = 0; i < DEPTH; i++) begin
            do_req(OP_INSERT, 16'h00A0 + 16'(i), 0, st, ad);
            check_eq("fill_addr", ad, i);
        end
        check_eq("fill_full", full, 1);
        do_req(OP_INSERT, 16'h00B0, 0, st, ad);
        check_eq("ins_when_full", st, ST_FULL);
        do_req(OP_DELETE, 16'h00A3, 0, st, ad);
        check_eq("del_a3_addr", ad, 3);
        do_req(OP_LOOKUP, 16'h00A3, 0, st, ad);
        check_eq("lookup_a3", st, ST_MISS);
        do_req(OP_INSERT, 16'h00C0, 0, st, ad);
        check_eq("reuse_addr", ad, 3);

        for (int n = 0; n < 200; n++) begin
            do_req(op_e'($urandom_range(0, 3)), 16'h00A0 + 16'($urandom_range(0, 11)),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0, st, ad);
        end

`ifdef CAM_CTRL_FLUSH_EN
        do_reset();
        for (int i = 0; i < 4; i++) do_req(OP_INSERT, 16'h0011 + 16'(i), 0, st, ad);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check_eq("flush_we", cam_we, 1);
            check_eq("flush_waddr", cam_waddr, i);
            check_eq("flush_wd", cam_wd, 0);
            check_eq("flush_req_ready", req_ready, 0);
        end
        @(negedge clk);
        check_eq("flush_empty", empty, 1);
        check_eq("flush_we_done", cam_we, 0);
        model_clear();
        do_req(OP_LOOKUP, 16'h0012, 0, st, ad);
        check_eq("flush_lookup", st, ST_MISS);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Request-side controller directly upstream of the team's multi-port CAM. It owns one CAM write port and one CAM read port.
- Serialises LOOKUP / INSERT / DELETE requests arriving over a valid/ready handshake.
- Keeps entries unique by searching before every insert. Tracks free entries and returns a status response per request.
- Stores a valid flag as the MSB of each CAM word. The CAM's all-zero reset state therefore reads as empty.

Parameters:
KEY, 16, key width; CAM data width is KEY+1 (bit KEY = valid)
DEPTH, 64, CAM entries
ADDR, $clog2(DEPTH), entry address width (derived, do not override)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous reset, active-low
req_valid  in  1  request valid
req_ready  out  1  controller accepts request (high only in IDLE)
req_op  in  2  operation code (package enum)
req_key  in  KEY  key
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_status  out  2  OK / MISS / DUP / FULL
rsp_addr  out  ADDR  entry address (hit/allocated/deleted; 0 otherwise)
occupancy  out  ADDR+1  valid entry count
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0
cam_we  out  1  to CAM write port 0
cam_wm  out  KEY+1  write mask (1 = keep bit)
cam_wd  out  KEY+1  write data
cam_waddr  out  ADDR  write address
cam_re  out  1  to CAM read port 0
cam_rm  out  KEY+1  search mask (1 = don't care)
cam_rd  out  KEY+1  search data
cam_match  in  1  from CAM
cam_raddr  in  ADDR  from CAM

Behaviour:
- Reset (sync, reset_n==0) clears:
  - state = IDLE; free bitmap = all ones; occupancy = 0.
  - All outputs 0 except empty=1. req_ready=1 only after reset deasserts.
- Reset mid-operation abandons the request silently and drops any pending response.
- The CAM is reset by the same system; this controller does not clear CAM cells.
- FSM IDLE -> SEARCH -> {WRITE} -> RESP -> IDLE.
  - IDLE: req_ready=1. On req_valid, latch op/key and go to SEARCH.
  - SEARCH (1 cycle):
    - Drive cam_re=1, cam_rd={1'b1,key}, cam_rm=0. The CAM read is combinational; register cam_match/cam_raddr.
    - LOOKUP: -> RESP; status OK (addr = raddr) on match, else MISS.
    - INSERT, match: -> RESP; status DUP, addr = raddr.
    - INSERT, no match: if full -> RESP with FULL, otherwise -> WRITE at the lowest free index.
    - DELETE, match: -> WRITE at raddr.
    - DELETE, no match: -> RESP with MISS.
    - Reserved op 2'b11: -> RESP; status MISS; no CAM access.
  - WRITE (1 cycle): cam_we=1, cam_wm=0.
    - INSERT: cam_wd = {1,key}; clear free bit; occupancy+1; status OK.
    - DELETE: cam_wd = {0,key}; set free bit; occupancy-1; status OK.
  - RESP: rsp_valid=1 with stable status/addr until rsp_ready. Then -> IDLE.
    - rsp_valid is registered; rsp_ready high on entry completes in that same cycle.
- Latency from request-handshake cycle to first rsp_valid:
  - LOOKUP, DUP, FULL, MISS: 2 cycles.
  - Successful INSERT/DELETE: 3 cycles.
- Throughput: one request per 3 or more cycles.
- The CAM write lands at the clock edge leaving WRITE, so the next request's SEARCH sees it. No bypass is required.
- cam_re / cam_we are 0 outside SEARCH / WRITE. Data/address outputs are don't-care when the enable is low and are driven 0.
- full/empty/occupancy update on the WRITE edge. Occupancy never wraps; the FULL check guarantees this.

Optional Feature:
- Macro CAM_CTRL_FLUSH_EN.
- Enabled: adds input port flush (1 bit).
  - Sampled only in IDLE; it takes priority over req_valid.
  - Enters FLUSH state: one write per cycle, address 0..DEPTH-1, cam_wm=0, cam_wd=0. req_ready=0 throughout.
  - After DEPTH cycles: free bitmap = all ones, occupancy = 0, -> IDLE.
  - No response is generated.
- Disabled: no flush port, no FLUSH state.

Decomposition:
- Package cam_ctrl_pkg:
  - op enum: OP_LOOKUP=0, OP_INSERT=1, OP_DELETE=2, OP_RSVD=3.
  - status enum: ST_OK=0, ST_MISS=1, ST_DUP=2, ST_FULL=3.
  - FSM state enum.
- Sub-module free_enc: lowest-set-bit priority encoder over the DEPTH free bitmap. Outputs index and any_free.

Test Plan:
- KEY=16, DEPTH=8. INSERT 0x1234 -> OK, addr 0, occupancy 1. INSERT 0x1234 again -> DUP, addr 0, occupancy 1.
- INSERT 0xA0..0xA7 -> OK, addr 0..7, full=1. INSERT 0xB0 -> FULL, no cam_we pulse.
- DELETE 0xA3 -> OK, addr 3. LOOKUP 0xA3 -> MISS. INSERT 0xC0 -> OK, addr 3 (lowest free reused).
- LOOKUP 0x0000 right after reset -> MISS (zeroed cells have valid=0). DELETE 0x5555 on empty -> MISS, occupancy stays 0.
- Hold rsp_ready=0 for 5 cycles: rsp fields stable, req_ready=0. Assert reset_n=0 during WRITE: next cycle rsp_valid=0, occupancy=0, state IDLE.
- With CAM_CTRL_FLUSH_EN, 4 entries valid: pulse flush -> 8 consecutive cam_we at addr 0..7, then empty=1, LOOKUP of a prior key -> MISS.
